// File: rtl/clk_ds_multi.sv
// clk_ds_multi: NUM_CH independent 50%-duty clock dividers with rising-edge ticks and
// run-time ratio reprogramming at full-period boundaries. Optional macro: CLK_DS_SYNC_EN.
`default_nettype none

module clk_ds_multi #(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
`ifdef CLK_DS_SYNC_EN
    input  logic                                   sync_i,
`endif
    input  logic                                   cfg_v_i,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] cfg_ch_i,
    input  logic [DIV_W-1:0]                       cfg_div_i,
    output logic                                   cfg_ready_o,
    input  logic [NUM_CH-1:0]                      en_i,
    output logic [NUM_CH-1:0]                      clk_o,
    output logic [NUM_CH-1:0]                      tick_o,
    output logic [NUM_CH-1:0]                      busy_o
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic sync_w;
`ifdef CLK_DS_SYNC_EN
    assign sync_w = sync_i;
`else
    assign sync_w = 1'b0;
`endif

    // Channel indices outside the array never match, so such writes stay ready and vanish.
    always_comb begin
        cfg_ready_o = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cfg_ch_i == CH_W'(c)) begin
                cfg_ready_o = ~busy_o[c];
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DIV_W-1:0] cur_div_q, cur_div_d;
        logic [DIV_W-1:0] pend_q, pend_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic             clk_q, clk_d;
        logic             busy_q, busy_d;
        logic             nz_w, last_w, count_w, acc_w, apply_w;

        assign nz_w    = (cur_div_q != '0);
        assign last_w  = (cnt_q == cur_div_q - DIV_W'(1));
        // A high phase already started keeps counting after enable drops.
        assign count_w = nz_w & (en_i[c] | clk_q);
        assign acc_w   = cfg_v_i & (cfg_ch_i == CH_W'(c)) & ~busy_q;

        assign clk_o[c]  = clk_q;
        assign busy_o[c] = busy_q;
        assign tick_o[c] = en_i[c] & nz_w & last_w & ~clk_q & ~reset_i;

        always_comb begin
            cur_div_d = cur_div_q;
            pend_d    = pend_q;
            cnt_d     = cnt_q;
            clk_d     = clk_q;
            busy_d    = busy_q;
            apply_w   = 1'b0;
            if (sync_w) begin
                cnt_d   = '0;
                clk_d   = 1'b0;
                apply_w = busy_q;
            end else if (count_w) begin
                if (last_w) begin
                    cnt_d   = '0;
                    clk_d   = ~clk_q;
                    apply_w = busy_q & clk_q;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end else begin
                cnt_d   = '0;
                clk_d   = 1'b0;
                apply_w = busy_q;
            end
            if (apply_w) begin
                cur_div_d = pend_q;
                busy_d    = 1'b0;
            end
            // Acceptance only happens when not busy, so it never races an apply.
            if (acc_w) begin
                pend_d = cfg_div_i;
                busy_d = 1'b1;
            end
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                cur_div_q <= DIV_W'(RESET_DIV);
                pend_q    <= '0;
                cnt_q     <= '0;
                clk_q     <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                cur_div_q <= cur_div_d;
                pend_q    <= pend_d;
                cnt_q     <= cnt_d;
                clk_q     <= clk_d;
                busy_q    <= busy_d;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_clk_ds_multi.sv
// tb_clk_ds_multi: randomized bench for clk_ds_multi against a period-position reference model.
`default_nettype none

module tb_clk_ds_multi;

    localparam int NUM_CH    = 4;
    localparam int DIV_W     = 8;
    localparam int RESET_DIV = 1;

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic                sync_i;
    logic                cfg_v_i;
    logic [1:0]          cfg_ch_i;
    logic [DIV_W-1:0]    cfg_div_i;
    logic                cfg_ready_o;
    logic [NUM_CH-1:0]   en_i;
    logic [NUM_CH-1:0]   clk_o;
    logic [NUM_CH-1:0]   tick_o;
    logic [NUM_CH-1:0]   busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: position within the full 2*D period, high when pos >= D.
    int m_div  [NUM_CH];
    int m_pos  [NUM_CH];
    int m_pend [NUM_CH];
    bit m_busy [NUM_CH];
    logic [NUM_CH-1:0] r_en;

    clk_ds_multi #(
        .NUM_CH    (NUM_CH),
        .DIV_W     (DIV_W),
        .RESET_DIV (RESET_DIV)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
`ifdef CLK_DS_SYNC_EN
        .sync_i      (sync_i),
`endif
        .cfg_v_i     (cfg_v_i),
        .cfg_ch_i    (cfg_ch_i),
        .cfg_div_i   (cfg_div_i),
        .cfg_ready_o (cfg_ready_o),
        .en_i        (en_i),
        .clk_o       (clk_o),
        .tick_o      (tick_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_div[c]  = RESET_DIV;
            m_pos[c]  = 0;
            m_pend[c] = 0;
            m_busy[c] = 1'b0;
        end
    endtask

    // Called just after a falling edge: drive, check, advance the model, wait for next falling edge.
    task automatic cycle(input logic [NUM_CH-1:0] en, input logic v, input int ch,
                         input int dv, input logic sy, output bit acc_o);
        logic [NUM_CH-1:0] e_clk, e_tick, e_busy;
        bit act, app, acc;
        en_i = en; cfg_v_i = v; cfg_ch_i = ch[1:0]; cfg_div_i = dv[DIV_W-1:0]; sync_i = sy;
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            e_clk[c]  = (m_div[c] != 0) && (m_pos[c] >= m_div[c]);
            e_tick[c] = en[c] && (m_div[c] != 0) && (m_pos[c] == m_div[c] - 1);
            e_busy[c] = m_busy[c];
        end
        chk("clk_o", int'(clk_o), int'(e_clk));
        chk("tick_o", int'(tick_o), int'(e_tick));
        chk("busy_o", int'(busy_o), int'(e_busy));
        chk("cfg_ready_o", int'(cfg_ready_o), int'((ch >= NUM_CH) || !m_busy[ch]));
        acc_o = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            acc = v && (ch == c) && !m_busy[c];
            act = (m_div[c] != 0) && (en[c] || (m_pos[c] >= m_div[c]));
            app = 1'b0;
            if (sy) begin
                m_pos[c] = 0;
                app = m_busy[c];
            end else if (act) begin
                m_pos[c]++;
                if (m_pos[c] == 2 * m_div[c]) begin
                    m_pos[c] = 0;
                    app = m_busy[c];
                end
            end else begin
                m_pos[c] = 0;
                app = m_busy[c];
            end
            if (app) begin
                m_div[c] = m_pend[c]; m_busy[c] = 1'b0; m_pos[c] = 0;
            end
            if (acc) begin
                m_pend[c] = dv; m_busy[c] = 1'b1; acc_o = 1'b1;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic run(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(r_en, 1'b0, 0, 0, 1'b0, a);
    endtask

    task automatic wr(input int ch, input int dv);
        bit a;
        a = 1'b0;
        for (int i = 0; i < 64 && !a; i++) cycle(r_en, 1'b1, ch, dv, 1'b0, a);
        if (!a) chk("wr_timeout", 0, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_clk_o"}, int'(clk_o), 0);
        chk({tag, "_tick_o"}, int'(tick_o), 0);
        chk({tag, "_busy_o"}, int'(busy_o), 0);
    endtask

    initial begin
        bit a;
        reset_i = 1'b1; sync_i = 1'b0; cfg_v_i = 1'b0; cfg_ch_i = '0; cfg_div_i = '0;
        en_i = '0; r_en = '0;
        repeat (2) @(negedge clk_i);
        check_zero("reset");
        reset_i = 1'b0;
        model_reset();

        r_en = 4'hF;
        run(10);
        wr(2, 3);
        run(20);
        wr(1, 4);
        run(12);
        for (int i = 0; i < 16 && m_pos[1] < m_div[1]; i++) run(1);
        r_en = 4'b1101;
        run(20);
        r_en = 4'hF;
        run(20);
        wr(0, 0);
        run(55);
        wr(0, 2);
        run(10);
        wr(3, 5);
        wr(3, 7);
        run(40);

        for (int i = 0; i < 3000; i++) begin
            bit sy;
            if ($urandom_range(0, 15) == 0) r_en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
            sy = 1'b0;
`ifdef CLK_DS_SYNC_EN
            sy = ($urandom_range(0, 63) == 0);
`endif
            cycle(r_en, ($urandom_range(0, 2) == 0), $urandom_range(0, NUM_CH - 1),
                  $urandom_range(0, 6), sy, a);
        end

        // Asynchronous reset between clock edges with channels active.
        en_i = 4'hF;
        #3 reset_i = 1'b1;
        #1 check_zero("midreset");
        chk("midreset_ready", int'(cfg_ready_o), 1);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        model_reset();
        r_en = 4'hF;
        run(200);

`ifdef CLK_DS_SYNC_EN
        wr(0, 2);
        wr(1, 3);
        run(7);
        cycle(r_en, 1'b0, 0, 0, 1'b1, a);
        chk("sync_low", int'(clk_o[1:0]), 0);
        run(10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
